misty_key_sched: RTL and testbench
==================================

MISTY_KEY_SCHED -- requirements
Module: misty_key_sched

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 8, meaning number of FO rounds served; only 8 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port aresetn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port valid_i  input  1  128-bit key offered.
REQ-005 SHALL have port key_i  input  128  K = K1||K2||...||K8, with K1 = key_i[127:112] and K8 = key_i[15:0].
REQ-006 SHALL have port ready_o  output  1  block can accept a key.
REQ-007 SHALL have port rnd_i  input  3  FO round select; 0..7 selects round 1..8.
REQ-008 SHALL have port key_O_o  output  64  KOi1||KOi2||KOi3||KOi4 for the selected round, with KOi1 in [63:48]; feeds FO key_O_i.
REQ-009 SHALL have port key_I_o  output  48  KIi1||KIi2||KIi3 for the selected round, with KIi1 in [47:32]; feeds FO key_I_i.
REQ-010 SHALL have port keys_valid_o  output  1  expanded key is complete and the key outputs are valid.

Function
REQ-011 SHALL accept a key on a handshake: posedge with valid_i && ready_o; key_i is latched into K1..K8 registers on that edge.
REQ-012 SHALL implement FSM IDLE -> EXPAND on handshake; EXPAND -> DONE after 8 cycles; DONE -> EXPAND on a new handshake.
REQ-013 SHALL drive ready_o = 1 in IDLE and DONE, and 0 in EXPAND.
REQ-014 SHALL in EXPAND compute one subkey per cycle with a 3-bit counter c = 0..7: K'(c+1) = FI(K(c+1), K(c+2)), with K9 = K1, and register K'(c+1) at the cycle end.
REQ-015 SHALL assert keys_valid_o exactly 9 posedges after the handshake edge (DURATION = 9), and keep it high while in DONE.
REQ-016 SHALL, for round i = rnd_i + 1, with all indices taken mod 8 in range 1..8:
- KOi1 = Ki, KOi2 = K(i+2), KOi3 = K(i+7), KOi4 = K(i+4)
- KIi1 = K'(i+5), KIi2 = K'(i+1), KIi3 = K'(i+3)
REQ-017 SHALL generate key_O_o and key_I_o combinationally from rnd_i, valid in the same cycle rnd_i changes, and force them to 0 whenever keys_valid_o = 0.
REQ-018 SHALL ignore valid_i while in EXPAND; the latched key and counter are unaffected.
REQ-019 SHALL, on a handshake in DONE, deassert keys_valid_o on the next posedge, overwrite K1..K8, and restart the counter at 0.
REQ-020 SHALL hold the key registers and K' registers stable in DONE, so rnd_i may change every cycle.

Reset
REQ-021 SHALL, while aresetn = 0, force the FSM to IDLE, the counter, K and K' registers to 0, keys_valid_o = 0 and ready_o = 0.
REQ-022 SHALL, when aresetn asserts mid-EXPAND, abort the expansion, with no partial keys_valid_o; after release, ready_o = 1 and a fresh key is required.

Structure
REQ-023 SHALL place the FSM state enum, DURATION = 9, and the KO/KI index offset constants in a shared package misty_key_sched_pkg.
REQ-024 SHALL instantiate exactly one sub-module, misty_fi: the combinational 16-bit FI function with a 16-bit key, the same FI used inside FO, time-shared over the 8 EXPAND cycles.

Verification
REQ-025 SHALL cover the standard vector: key_i = 00112233445566778899aabbccddeeff, then handshake -> keys_valid_o high after 9 clocks; the K' registers equal cf51, 8e7f, 5e29, 673a, cdbc, 07d6, bf35, 5e11.
REQ-026 SHALL cover round select with the same key: rnd_i = 0 -> key_O_o = 00114455eeff8899, key_I_o = 07d68e7f673a; rnd_i = 7 -> key_O_o = eeff2233ccdd6677, key_I_o = cdbccf515e29.
REQ-027 SHALL cover valid_i held high during EXPAND with a different key_i -> ready_o = 0 throughout, and results equal the first key's.
REQ-028 SHALL cover aresetn pulsed low at EXPAND cycle 4 -> keys_valid_o stays 0, outputs read 0, and ready_o = 1 after release.
REQ-029 SHALL cover a second key accepted in DONE -> keys_valid_o low on the next cycle and high again 9 clocks after the handshake, with new values.
REQ-030 SHALL check, via an interface assertion, that valid_i && ready_o implies keys_valid_o at ##DURATION, and SHALL cover the handshake-in-DONE case.

Source files
------------

// File: rtl/misty_key_sched_pkg.sv
// Shared types and constants for the MISTY1 key schedule: FSM encoding,
// handshake-to-valid latency and the per-round subkey index offsets.
package misty_key_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXPAND = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   localparam int DURATION = 9;

   // Entry [3] lands in the top slice of key_O_o (KOi1), entry [0] in KOi4.
   localparam logic [3:0][2:0] KO_OFF = {3'd0, 3'd2, 3'd7, 3'd4};
   localparam logic [2:0][2:0] KI_OFF = {3'd5, 3'd1, 3'd3};

   // Zero-based round plus offset; the 3-bit wrap gives the mod-8 indexing.
   function automatic logic [2:0] rnd_idx(input logic [2:0] rnd, input logic [2:0] off);
      return rnd + off;
   endfunction

endpackage

// File: rtl/misty_fi.sv
// MISTY1 FI: combinational 16-bit S9/S7/S9 network keyed by a 16-bit subkey.
module misty_fi (
   input  logic [15:0] in_i,
   input  logic [15:0] key_i,
   output logic [15:0] out_o
);

   localparam logic [6:0] S7 [0:127] = '{
      7'h1b,7'h32,7'h33,7'h5a,7'h3b,7'h10,7'h17,7'h54,7'h5b,7'h1a,7'h72,7'h73,7'h6b,7'h2c,7'h66,7'h49,
      7'h1f,7'h24,7'h13,7'h6c,7'h37,7'h2e,7'h3f,7'h4a,7'h5d,7'h0f,7'h40,7'h56,7'h25,7'h51,7'h1c,7'h04,
      7'h0b,7'h46,7'h20,7'h0d,7'h7b,7'h35,7'h44,7'h42,7'h2b,7'h1e,7'h41,7'h14,7'h4b,7'h79,7'h15,7'h6f,
      7'h0e,7'h55,7'h09,7'h36,7'h74,7'h0c,7'h67,7'h53,7'h28,7'h0a,7'h7e,7'h38,7'h02,7'h07,7'h60,7'h29,
      7'h19,7'h12,7'h65,7'h2f,7'h30,7'h39,7'h08,7'h68,7'h5f,7'h78,7'h2a,7'h4c,7'h64,7'h45,7'h75,7'h3d,
      7'h59,7'h48,7'h03,7'h57,7'h7c,7'h4f,7'h62,7'h3c,7'h1d,7'h21,7'h5e,7'h27,7'h6a,7'h70,7'h4d,7'h3a,
      7'h01,7'h6d,7'h6e,7'h63,7'h18,7'h77,7'h23,7'h05,7'h26,7'h76,7'h00,7'h31,7'h2d,7'h7a,7'h7f,7'h61,
      7'h50,7'h22,7'h11,7'h06,7'h47,7'h16,7'h52,7'h4e,7'h71,7'h3e,7'h69,7'h43,7'h34,7'h5c,7'h58,7'h7d
   };

   localparam logic [8:0] S9 [0:511] = '{
      9'h1c3,9'h0cb,9'h153,9'h19f,9'h1e3,9'h0e9,9'h0fb,9'h035,9'h181,9'h0b9,9'h117,9'h1eb,9'h133,9'h009,9'h02d,9'h0d3,
      9'h0c7,9'h14a,9'h037,9'h07e,9'h0eb,9'h164,9'h193,9'h1d8,9'h0a3,9'h11e,9'h055,9'h02c,9'h01d,9'h1a2,9'h163,9'h118,
      9'h14b,9'h152,9'h1d2,9'h00f,9'h02b,9'h030,9'h13a,9'h0e5,9'h111,9'h138,9'h18e,9'h063,9'h0e3,9'h0c8,9'h1f4,9'h01b,
      9'h001,9'h09d,9'h0f8,9'h1a0,9'h16d,9'h1f3,9'h01c,9'h146,9'h07d,9'h0d1,9'h082,9'h1ea,9'h183,9'h12d,9'h0f4,9'h19e,
      9'h1d3,9'h0dd,9'h1e2,9'h128,9'h1e0,9'h0ec,9'h059,9'h091,9'h011,9'h12f,9'h026,9'h0dc,9'h0b0,9'h18c,9'h10f,9'h1f7,
      9'h0e7,9'h16c,9'h0b6,9'h0f9,9'h0d8,9'h151,9'h101,9'h14c,9'h103,9'h0b8,9'h154,9'h12b,9'h1ae,9'h017,9'h071,9'h00c,
      9'h047,9'h058,9'h07f,9'h1a4,9'h134,9'h129,9'h084,9'h15d,9'h19d,9'h1b2,9'h1a3,9'h048,9'h07c,9'h051,9'h1ca,9'h023,
      9'h13d,9'h1a7,9'h165,9'h03b,9'h042,9'h0da,9'h192,9'h0ce,9'h0c1,9'h06b,9'h09f,9'h1f1,9'h12c,9'h184,9'h0fa,9'h196,
      9'h1e1,9'h169,9'h17d,9'h031,9'h180,9'h10a,9'h094,9'h1da,9'h186,9'h13e,9'h11c,9'h060,9'h175,9'h1cf,9'h067,9'h119,
      9'h065,9'h068,9'h099,9'h150,9'h008,9'h007,9'h17c,9'h0b7,9'h024,9'h019,9'h0de,9'h127,9'h0db,9'h0e4,9'h1a9,9'h052,
      9'h109,9'h090,9'h19c,9'h1c1,9'h028,9'h1b3,9'h135,9'h16a,9'h176,9'h0df,9'h1e5,9'h188,9'h0c5,9'h16e,9'h1de,9'h1b1,
      9'h0c3,9'h1df,9'h036,9'h0ee,9'h1ee,9'h0f0,9'h093,9'h049,9'h09a,9'h1b6,9'h069,9'h081,9'h125,9'h00b,9'h05e,9'h0b4,
      9'h149,9'h1c7,9'h174,9'h03e,9'h13b,9'h1b7,9'h08e,9'h1c6,9'h0ae,9'h010,9'h095,9'h1ef,9'h04e,9'h0f2,9'h1fd,9'h085,
      9'h0fd,9'h0f6,9'h0a0,9'h16f,9'h083,9'h08a,9'h156,9'h09b,9'h13c,9'h107,9'h167,9'h098,9'h1d0,9'h1e9,9'h003,9'h1fe,
      9'h0bd,9'h122,9'h089,9'h0d2,9'h18f,9'h012,9'h033,9'h06a,9'h142,9'h0ed,9'h170,9'h11b,9'h0e2,9'h14f,9'h158,9'h131,
      9'h147,9'h05d,9'h113,9'h1cd,9'h079,9'h161,9'h1a5,9'h179,9'h09e,9'h1b4,9'h0cc,9'h022,9'h132,9'h01a,9'h0e8,9'h004,
      9'h187,9'h1ed,9'h197,9'h039,9'h1bf,9'h1d7,9'h027,9'h18b,9'h0c6,9'h09c,9'h0d0,9'h14e,9'h06c,9'h034,9'h1f2,9'h06e,
      9'h0ca,9'h025,9'h0ba,9'h191,9'h0fe,9'h013,9'h106,9'h02f,9'h1ad,9'h172,9'h1db,9'h0c0,9'h10b,9'h1d6,9'h0f5,9'h1ec,
      9'h10d,9'h076,9'h114,9'h1ab,9'h075,9'h10c,9'h1e4,9'h159,9'h054,9'h11f,9'h04b,9'h0c4,9'h1be,9'h0f7,9'h029,9'h0a4,
      9'h00e,9'h1f0,9'h077,9'h04d,9'h17a,9'h086,9'h08b,9'h0b3,9'h171,9'h0bf,9'h10e,9'h104,9'h097,9'h15b,9'h160,9'h168,
      9'h0d7,9'h0bb,9'h066,9'h1ce,9'h0fc,9'h092,9'h1c5,9'h06f,9'h016,9'h04a,9'h0a1,9'h139,9'h0af,9'h0f1,9'h190,9'h00a,
      9'h1aa,9'h143,9'h17b,9'h056,9'h18d,9'h166,9'h0d4,9'h1fb,9'h14d,9'h194,9'h19a,9'h087,9'h1f8,9'h123,9'h0a7,9'h1b8,
      9'h141,9'h03c,9'h1f9,9'h140,9'h02a,9'h155,9'h11a,9'h1a1,9'h198,9'h0d5,9'h126,9'h1af,9'h061,9'h12e,9'h157,9'h1dc,
      9'h072,9'h18a,9'h0aa,9'h096,9'h115,9'h0ef,9'h045,9'h07b,9'h08d,9'h145,9'h053,9'h05f,9'h178,9'h0b2,9'h02e,9'h020,
      9'h1d5,9'h03f,9'h1c9,9'h1e7,9'h1ac,9'h044,9'h038,9'h014,9'h0b1,9'h16b,9'h0ab,9'h0b5,9'h05a,9'h182,9'h1c8,9'h1d4,
      9'h018,9'h177,9'h064,9'h0cf,9'h06d,9'h100,9'h199,9'h130,9'h15a,9'h005,9'h120,9'h1bb,9'h1bd,9'h0e0,9'h04f,9'h0d6,
      9'h13f,9'h1c4,9'h12a,9'h015,9'h006,9'h0ff,9'h19b,9'h0a6,9'h043,9'h088,9'h050,9'h15f,9'h1e8,9'h121,9'h073,9'h17e,
      9'h0bc,9'h0c2,9'h0c9,9'h173,9'h189,9'h1f5,9'h074,9'h1cc,9'h1e6,9'h1a8,9'h195,9'h01f,9'h041,9'h00d,9'h1ba,9'h032,
      9'h03d,9'h1d1,9'h080,9'h0a8,9'h057,9'h1b9,9'h162,9'h148,9'h0d9,9'h105,9'h062,9'h07a,9'h021,9'h1ff,9'h112,9'h108,
      9'h1c0,9'h0a9,9'h11d,9'h1b0,9'h1a6,9'h0cd,9'h0f3,9'h05c,9'h102,9'h05b,9'h1d9,9'h144,9'h1f6,9'h0ad,9'h0a5,9'h03a,
      9'h1cb,9'h136,9'h17f,9'h046,9'h0e1,9'h01e,9'h1dd,9'h0e6,9'h137,9'h1fa,9'h185,9'h08c,9'h08f,9'h040,9'h1b5,9'h0be,
      9'h078,9'h000,9'h0ac,9'h110,9'h15e,9'h124,9'h002,9'h1bc,9'h0a2,9'h0ea,9'h070,9'h1fc,9'h116,9'h15c,9'h04c,9'h1c2
   };

   logic [8:0] d9a, d9b, d9c;
   logic [6:0] d7a, d7b;

   always_comb begin
      d9a   = S9[in_i[15:7]] ^ {2'b00, in_i[6:0]};
      d7a   = S7[in_i[6:0]] ^ d9a[6:0];
      d7b   = d7a ^ key_i[15:9];
      d9b   = d9a ^ key_i[8:0];
      d9c   = S9[d9b] ^ {2'b00, d7b};
      out_o = {d7b, d9c};
   end

endmodule

// File: rtl/misty_key_sched.sv
// MISTY1 key schedule: latches K1..K8, derives K'1..K'8 with one shared FI
// over eight cycles, then serves per-round KO/KI subkeys selected by rnd_i.
module misty_key_sched
   import misty_key_sched_pkg::*;
#(
   parameter int NUM_ROUNDS = 8
) (
   input  logic         clk,
   input  logic         aresetn,
   input  logic         valid_i,
   input  logic [127:0] key_i,
   output logic         ready_o,
   input  logic [2:0]   rnd_i,
   output logic [63:0]  key_O_o,
   output logic [47:0]  key_I_o,
   output logic         keys_valid_o
);

   localparam logic [2:0] LAST_CNT = 3'(NUM_ROUNDS - 1);

   state_e           state_q;
   logic [2:0]       cnt_q;
   logic [2:0]       cnt_nx;
   logic [7:0][15:0] k_q;
   logic [7:0][15:0] kp_q;
   logic             ready_q;
   logic             kv_q;
   logic             hs;
   logic [15:0]      fi_out;

   assign cnt_nx = cnt_q + 3'd1;
   assign hs     = valid_i && ready_q;

   // K(c+2) for c = 7 wraps to K1 through the 3-bit index.
   misty_fi u_fi (
      .in_i  (k_q[cnt_q]),
      .key_i (k_q[cnt_nx]),
      .out_o (fi_out)
   );

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         k_q     <= '0;
         kp_q    <= '0;
         ready_q <= 1'b0;
         kv_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (hs) begin
                  state_q <= ST_EXPAND;
                  cnt_q   <= '0;
                  ready_q <= 1'b0;
                  kv_q    <= 1'b0;
                  for (int j = 0; j < 8; j++) k_q[j] <= key_i[127-16*j -: 16];
               end else begin
                  ready_q <= 1'b1;
               end
            end
            ST_EXPAND: begin
               kp_q[cnt_q] <= fi_out;
               cnt_q       <= cnt_nx;
               // kv rises with the last K' so it samples high DURATION edges after the handshake
               if (cnt_q == LAST_CNT) begin
                  state_q <= ST_DONE;
                  ready_q <= 1'b1;
                  kv_q    <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign ready_o      = ready_q;
   assign keys_valid_o = kv_q;

   always_comb begin
      key_O_o = '0;
      key_I_o = '0;
      if (kv_q) begin
         for (int j = 0; j < 4; j++) key_O_o[16*j +: 16] = k_q[rnd_idx(rnd_i, KO_OFF[j])];
         for (int j = 0; j < 3; j++) key_I_o[16*j +: 16] = kp_q[rnd_idx(rnd_i, KI_OFF[j])];
      end
   end

endmodule

// File: tb/tb_misty_key_sched.sv
// Directed bench for misty_key_sched using the MISTY1 reference key and a
// word-rotated copy of it, whose K' values are the reference K' rotated.
module tb_misty_key_sched;
   import misty_key_sched_pkg::*;

   logic         clk = 1'b0;
   logic         aresetn = 1'b0;
   logic         valid_i = 1'b0;
   logic [127:0] key_i = '0;
   logic [2:0]   rnd_i = '0;
   logic         ready_o;
   logic [63:0]  key_O_o;
   logic [47:0]  key_I_o;
   logic         keys_valid_o;

   int n_chk = 0;
   int n_fail = 0;

   localparam logic [127:0] KEY1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY2 = 128'h2233445566778899aabbccddeeff0011;
   localparam logic [127:0] KEYX = 128'hffffffffffffffffffffffffffffffff;

   logic [15:0] kp1 [8] = '{16'hcf51, 16'h8e7f, 16'h5e29, 16'h673a,
                            16'hcdbc, 16'h07d6, 16'hbf35, 16'h5e11};

   always #5 clk = ~clk;

   misty_key_sched #(.NUM_ROUNDS(8)) dut (
      .clk          (clk),
      .aresetn      (aresetn),
      .valid_i      (valid_i),
      .key_i        (key_i),
      .ready_o      (ready_o),
      .rnd_i        (rnd_i),
      .key_O_o      (key_O_o),
      .key_I_o      (key_I_o),
      .keys_valid_o (keys_valid_o)
   );

   property p_hs_valid;
      @(posedge clk) disable iff (!aresetn) (valid_i && ready_o) |-> ##DURATION keys_valid_o;
   endproperty
   a_hs_valid: assert property (p_hs_valid)
      else begin n_fail++; $error("FAIL hs_to_valid: keys_valid_o=0 required=1"); end
   c_hs_done: cover property (@(posedge clk) disable iff (!aresetn) valid_i && ready_o && keys_valid_o);

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp)
         else begin n_fail++; $error("FAIL %s: observed=%h expected=%h", tag, obs, exp); end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_ready", 64'(ready_o), 64'd0);
      chk("rst_kv", 64'(keys_valid_o), 64'd0);
      chk("rst_keyO", key_O_o, 64'd0);
      chk("rst_keyI", 64'(key_I_o), 64'd0);
      aresetn = 1'b1;
      tick();
      chk("rel_ready", 64'(ready_o), 64'd1);

      // reference key from IDLE
      key_i = KEY1; valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      chk("hs1_ready", 64'(ready_o), 64'd0);
      for (int i = 1; i <= 8; i++) begin
         tick();
         chk($sformatf("exp1_kv_e%0d", i), 64'(keys_valid_o), 64'(i == 8));
      end
      chk("done1_ready", 64'(ready_o), 64'd1);
      for (int j = 0; j < 8; j++) chk($sformatf("kp1_%0d", j + 1), 64'(dut.kp_q[j]), 64'(kp1[j]));
      rnd_i = 3'd0; #1;
      chk("r0_keyO", key_O_o, 64'h00114455eeff8899);
      chk("r0_keyI", 64'(key_I_o), 64'h07d68e7f673a);
      rnd_i = 3'd7; #1;
      chk("r7_keyO", key_O_o, 64'heeff2233ccdd6677);
      chk("r7_keyI", 64'(key_I_o), 64'hcdbccf515e29);
      rnd_i = 3'd3; #1;
      chk("r3_keyO", key_O_o, 64'h6677aabb4455eeff);
      chk("r3_keyI", 64'(key_I_o), 64'hcf51cdbcbf35);
      rnd_i = 3'd0;
      @(negedge clk);

      // valid_i held during EXPAND with a different key
      key_i = KEY1; valid_i = 1'b1;
      tick();
      key_i = KEYX;
      chk("hs2_kv_low", 64'(keys_valid_o), 64'd0);
      for (int i = 1; i <= 8; i++) begin
         tick();
         chk($sformatf("hold_ready_e%0d", i), 64'(ready_o), 64'(i == 8));
      end
      valid_i = 1'b0;
      chk("hold_kv", 64'(keys_valid_o), 64'd1);
      chk("hold_keyO", key_O_o, 64'h00114455eeff8899);
      chk("hold_keyI", 64'(key_I_o), 64'h07d68e7f673a);
      chk("hold_kp8", 64'(dut.kp_q[7]), 64'h5e11);

      // reset pulse in the middle of an expansion
      key_i = KEY1; valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      repeat (4) tick();
      aresetn = 1'b0; #1;
      chk("midrst_kv", 64'(keys_valid_o), 64'd0);
      chk("midrst_ready", 64'(ready_o), 64'd0);
      chk("midrst_keyO", key_O_o, 64'd0);
      chk("midrst_keyI", 64'(key_I_o), 64'd0);
      chk("midrst_kp_clr", 64'(|dut.kp_q), 64'd0);
      tick();
      aresetn = 1'b1;
      tick();
      chk("postrst_ready", 64'(ready_o), 64'd1);
      repeat (10) tick();
      chk("postrst_kv", 64'(keys_valid_o), 64'd0);
      chk("postrst_keyO", key_O_o, 64'd0);

      // second key accepted while DONE
      key_i = KEY1; valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      repeat (8) tick();
      chk("pre2_kv", 64'(keys_valid_o), 64'd1);
      key_i = KEY2; valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      chk("hs_done_kv_low", 64'(keys_valid_o), 64'd0);
      for (int i = 1; i <= 8; i++) begin
         tick();
         chk($sformatf("exp2_kv_e%0d", i), 64'(keys_valid_o), 64'(i == 8));
      end
      chk("k2_r0_keyO", key_O_o, 64'h22336677_0011aabb);
      chk("k2_r0_keyI", 64'(key_I_o), 64'hbf355e29cdbc);
      for (int j = 0; j < 8; j++)
         chk($sformatf("kp2_%0d", j + 1), 64'(dut.kp_q[j]), 64'(kp1[(j + 1) % 8]));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
